// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared types and constants for the memory responder
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Feedback taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3 of a left-shifting register)
    localparam logic [7:0] LFSR_TAPS   = 8'hB8;
    localparam int         MAX_LATENCY = 15;
    localparam int         CNT_W       = 4;

    function automatic logic [7:0] lfsrNext(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - 8-bit Fibonacci LFSR, advances whenever en is high
module lfsr8
    import mem_responder_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= SEED;
        end else if (en) begin
            q <= lfsrNext(q);
        end
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-port SRAM responder with programmable response latency
// MEM_RESPONDER_RAND_DELAY_EN adds 0..7 pseudo-random extra cycles per request.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 1,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [31:0] SPAN_BYTES = 32'(4) << DEPTH_LOG2;

    state_t                  state;
    logic [CNT_W-1:0]        delayCnt;
    logic [CNT_W-1:0]        cntLoad;
    logic [31:0]             offset;
    logic [DEPTH_LOG2-1:0]   wordIdx;
    logic                    outOfRange;
    logic                    accept;
    logic [31:0]             memArray [DEPTH];

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;

    // Unsigned wrap makes addresses below BASE_ADDR land far above the span.
    assign offset     = req_addr - BASE_ADDR;
    assign outOfRange = (offset >= SPAN_BYTES);
    assign wordIdx    = offset[DEPTH_LOG2+1:2];

`ifdef MEM_RESPONDER_RAND_DELAY_EN
    logic [7:0] lfsrQ;
    logic [2:0] extraDelay;

    lfsr8 #(
        .SEED (LFSR_SEED)
    ) uLfsr (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .q   (lfsrQ)
    );

    assign extraDelay = 3'(lfsrQ & 8'h07);
    // LATENCY + 7 must still fit the counter, so LATENCY is limited to 9 here.
    assign cntLoad    = CNT_W'(LATENCY - 1) + {{(CNT_W-3){1'b0}}, extraDelay};
`else
    assign cntLoad    = CNT_W'(LATENCY - 1);
`endif

    always_ff @(posedge clk) begin
        if (accept && req_wen && !outOfRange) begin
            for (int b = 0; b < 4; b++) begin
                if (req_wmask[b]) begin
                    memArray[wordIdx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            delayCnt  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rsp_err   <= outOfRange;
                        rsp_rdata <= (!outOfRange && !req_wen) ? memArray[wordIdx] : 32'h0;
                        delayCnt  <= cntLoad;
                        state     <= (cntLoad == '0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (delayCnt == '0) begin
                        state <= RESP;
                    end else begin
                        delayCnt <= delayCnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder (LATENCY=3)
module tb_mem_responder;

    localparam int LAT = 3;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          delay;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wmask = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    exp_t        sbQ[$];
    int          nChecks = 0;
    int          nPass = 0;
    logic [7:0]  refLfsr;

    mem_responder #(
        .BASE_ADDR  (32'h8000_0000),
        .DEPTH_LOG2 (12),
        .LATENCY    (LAT),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    // Reference x^8+x^6+x^5+x^4+1 generator, free-running like the delay source
    always @(posedge clk or negedge rst) begin
        if (!rst) refLfsr <= 8'hA5;
        else      refLfsr <= {refLfsr[6:0], refLfsr[7] ^ refLfsr[5] ^ refLfsr[4] ^ refLfsr[3]};
    end

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else             nPass++;
    endtask

    task automatic acceptReq(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] mask, input logic [31:0] expRdata, input logic expErr);
        exp_t e;
        int   w;
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = mask;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        checkEq("reqReady", 32'(req_ready), 32'd1);
        e.rdata = expRdata;
        e.err   = expErr;
`ifdef MEM_RESPONDER_RAND_DELAY_EN
        e.delay = LAT + int'(refLfsr[2:0]);
`else
        e.delay = LAT;
`endif
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_wmask = 4'h0;
    endtask

    task automatic collectRsp(input int hold);
        exp_t e;
        int   cyc;
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (sbQ.size() == 0) begin
            checkEq("sbNotEmpty", 32'd0, 32'd1);
            return;
        end
        e = sbQ.pop_front();
        checkEq("delay", 32'(cyc), 32'(e.delay));
`ifdef MEM_RESPONDER_RAND_DELAY_EN
        checkEq("delayRange", 32'(cyc >= 3 && cyc <= 10), 32'd1);
`endif
        checkEq("rdata", rsp_rdata, e.rdata);
        checkEq("err", 32'(rsp_err), 32'(e.err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkEq("holdValid", 32'(rsp_valid), 32'd1);
            checkEq("holdRdata", rsp_rdata, e.rdata);
            checkEq("holdReady", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checkEq("postValid", 32'(rsp_valid), 32'd0);
        checkEq("postReady", 32'(req_ready), 32'd1);
    endtask

    task automatic doReq(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask, input logic [31:0] expRdata, input logic expErr,
                         input int hold);
        acceptReq(wen, addr, wdata, mask, expRdata, expErr);
        collectRsp(hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkEq("rstValid", 32'(rsp_valid), 32'd0);
        checkEq("rstErr", 32'(rsp_err), 32'd0);
        checkEq("rstRdata", rsp_rdata, 32'h0);
        checkEq("rstReady", 32'(req_ready), 32'd1);

        doReq(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 0);
        doReq(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0);

        doReq(1'b1, 32'h8000_0010, 32'h0000_AB00, 4'b0010, 32'h0, 1'b0, 0);
        doReq(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_ABEF, 1'b0, 0);

        doReq(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_ABEF, 1'b0, 5);

        doReq(1'b1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, 0);
        doReq(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1, 0);
        doReq(1'b1, 32'h8000_4000, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 0);
        doReq(1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 0);
        doReq(1'b0, 32'h8000_3FFC, 32'h0, 4'h0, 32'h0, 1'b0, 0);

        acceptReq(1'b1, 32'h8000_0020, 32'hCAFE_1234, 4'hF, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkEq("midRstValid", 32'(rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sbQ.delete();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkEq("abandonValid", 32'(rsp_valid), 32'd0);
            checkEq("abandonReady", 32'(req_ready), 32'd1);
        end
        doReq(1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'hCAFE_1234, 1'b0, 0);

`ifdef MEM_RESPONDER_RAND_DELAY_EN
        for (int i = 0; i < 100; i++) begin
            doReq(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_ABEF, 1'b0, 0);
        end
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
